instr_sequencer: RTL and testbench

- Multicycle phase controller for the KGP-RISC core.
- Steps each instruction through fetch, decode, execute, memory and writeback phases.
- Drives the enables for the program counter, instruction register, instruction/data BRAMs and register file, inserting wait cycles for BRAM read latency.
- Sits between main_control, which supplies the instruction class, and the datapath registers and memories.

---
 rtl/instr_sequencer_if.sv | 29 ++
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Handshake bundle between main_control/datapath and the phase sequencer.
// The master side supplies run control and the instruction class; the slave side is the sequencer.
interface instr_sequencer_if;
  logic        start;
  logic        halt_req;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic [1:0]  branch;
  logic        pc_en;
  logic        ir_load;
  logic        imem_en;
  logic        dmem_en;
  logic        dmem_we;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;
  logic [31:0] instr_count;

  modport master (
    output start, halt_req, mem_read, mem_write, reg_write, branch,
    input  pc_en, ir_load, imem_en, dmem_en, dmem_we, rf_we, state, halted, instr_count
  );

  modport slave (
    input  start, halt_req, mem_read, mem_write, reg_write, branch,
    output pc_en, ir_load, imem_en, dmem_en, dmem_we, rf_we, state, halted, instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multicycle phase controller for the KGP-RISC core: fetch/decode/exec/mem/writeback
// with wait cycles for BRAM latency. branch is informational and does not affect sequencing.
module instr_sequencer #(
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned DMEM_LAT = 1
) (
  input logic               clock,
  input logic               reset,
  instr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] IMEM_LAST = 3'(IMEM_LAT);
  localparam logic [2:0] DMEM_LAST = 3'(DMEM_LAT);

  state_t      state_r;
  logic [2:0]  lat_r;
  logic        halt_pend_r;
  logic [31:0] instr_count_r;

  logic imem_en_s, ir_load_s, dmem_en_s, dmem_we_s, rf_we_s, retire_s;
  logic is_mem_s, load_wb_s;

  assign is_mem_s  = bus.mem_read | bus.mem_write;
  // A simultaneous read+write is treated as a store, so it never reaches WB.
  assign load_wb_s = bus.mem_read & ~bus.mem_write & bus.reg_write;

  // Strobe decode from the registered phase, latency counter and class inputs.
  always_comb begin
    imem_en_s = 1'b0;
    ir_load_s = 1'b0;
    dmem_en_s = 1'b0;
    dmem_we_s = 1'b0;
    rf_we_s   = 1'b0;
    retire_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        imem_en_s = 1'b1;
        ir_load_s = (lat_r == IMEM_LAST);
      end
      S_EXEC: begin
        retire_s = ~is_mem_s & ~bus.reg_write;
      end
      S_MEM: begin
        dmem_en_s = 1'b1;
        dmem_we_s = bus.mem_write & (lat_r == 3'd0);
        retire_s  = (lat_r == DMEM_LAST) & ~load_wb_s;
      end
      S_WB: begin
        rf_we_s  = 1'b1;
        retire_s = 1'b1;
      end
      default: begin
        retire_s = 1'b0;
      end
    endcase
  end

  // Phase sequencing, halt-pending tracking and retired-instruction count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r       <= S_IDLE;
      lat_r         <= 3'd0;
      halt_pend_r   <= 1'b0;
      instr_count_r <= 32'd0;
    end else if (retire_s) begin
      instr_count_r <= instr_count_r + 32'd1;
      lat_r         <= 3'd0;
      if (halt_pend_r || bus.halt_req) begin
        state_r     <= S_HALT;
        halt_pend_r <= 1'b0;
      end else begin
        state_r <= S_FETCH;
      end
    end else begin
      if (bus.halt_req && (state_r != S_IDLE) && (state_r != S_HALT)) begin
        halt_pend_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            state_r <= S_FETCH;
            lat_r   <= 3'd0;
          end
        end
        S_FETCH: begin
          if (lat_r == IMEM_LAST) begin
            state_r <= S_DECODE;
            lat_r   <= 3'd0;
          end else begin
            lat_r <= lat_r + 3'd1;
          end
        end
        S_DECODE: begin
          state_r <= S_EXEC;
        end
        S_EXEC: begin
          lat_r   <= 3'd0;
          state_r <= is_mem_s ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (lat_r == DMEM_LAST) begin
            state_r <= S_WB;
            lat_r   <= 3'd0;
          end else begin
            lat_r <= lat_r + 3'd1;
          end
        end
        S_HALT: begin
          if (bus.start && !bus.halt_req) begin
            state_r <= S_FETCH;
            lat_r   <= 3'd0;
          end
        end
        default: begin
          state_r <= S_IDLE;
          lat_r   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.imem_en     = imem_en_s;
  assign bus.ir_load     = ir_load_s;
  assign bus.dmem_en     = dmem_en_s;
  assign bus.dmem_we     = dmem_we_s;
  assign bus.rf_we       = rf_we_s;
  assign bus.pc_en       = retire_s;
  assign bus.state       = state_r;
  assign bus.halted      = (state_r == S_HALT);
  assign bus.instr_count = instr_count_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer; expected per-cycle traces are
// built from the phase rules (fetch length, mem length, WB/retire placement).
module tb_instr_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, halt_req = 1'b0, mr = 1'b0, mw = 1'b0, rw = 1'b0;
  logic [1:0] br = 2'b00;
  logic sel = 1'b0;

  instr_sequencer_if ifa();
  instr_sequencer_if ifb();

  assign ifa.start = start;  assign ifb.start = start;
  assign ifa.halt_req = halt_req;  assign ifb.halt_req = halt_req;
  assign ifa.mem_read = mr;  assign ifb.mem_read = mr;
  assign ifa.mem_write = mw;  assign ifb.mem_write = mw;
  assign ifa.reg_write = rw;  assign ifb.reg_write = rw;
  assign ifa.branch = br;  assign ifb.branch = br;

  instr_sequencer #(.IMEM_LAT(1), .DMEM_LAT(1)) dut_a (.clock(clock), .reset(reset), .bus(ifa.slave));
  instr_sequencer #(.IMEM_LAT(1), .DMEM_LAT(3)) dut_b (.clock(clock), .reset(reset), .bus(ifb.slave));

  always #5 clock = ~clock;

  wire [8:0] vec_a = {ifa.state, ifa.imem_en, ifa.ir_load, ifa.dmem_en, ifa.dmem_we, ifa.rf_we, ifa.pc_en};
  wire [8:0] vec_b = {ifb.state, ifb.imem_en, ifb.ir_load, ifb.dmem_en, ifb.dmem_we, ifb.rf_we, ifb.pc_en};
  wire [8:0]  obs_vec    = sel ? vec_b : vec_a;
  wire        obs_halted = sel ? ifb.halted : ifa.halted;
  wire [31:0] obs_count  = sel ? ifb.instr_count : ifa.instr_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cur_im = 1;
  int cur_dm = 1;
  logic [31:0] exp_count = 32'd0;
  logic last_halt = 1'b0;
  logic release_at_retire = 1'b0;
  logic [8:0] tq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [8:0] pk(input int st, input logic ie, input logic il,
                                    input logic de, input logic dw, input logic rf, input logic pc);
    return {3'(st), ie, il, de, dw, rf, pc};
  endfunction

  // Expected trace: one entry per cycle from the first FETCH cycle to the retire cycle.
  task automatic build(input logic imr, input logic imw, input logic irw);
    logic is_mem, wb;
    is_mem = imr | imw;
    wb = is_mem ? (imr && !imw && irw) : irw;
    tq.delete();
    for (int k = 0; k <= cur_im; k++) tq.push_back(pk(1, 1'b1, k == cur_im, 1'b0, 1'b0, 1'b0, 1'b0));
    tq.push_back(pk(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tq.push_back(pk(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, !is_mem && !irw));
    if (is_mem)
      for (int k = 0; k <= cur_dm; k++)
        tq.push_back(pk(4, 1'b0, 1'b0, 1'b1, (k == 0) && imw, 1'b0, (k == cur_dm) && !wb));
    if (wb) tq.push_back(pk(5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
  endtask

  // Entered at the negedge of the first FETCH cycle; leaves at the negedge after retire.
  task automatic exec_instr(input logic imr, input logic imw, input logic irw,
                            input logic [1:0] ibr, input int hcyc, input string nm);
    mr = imr; mw = imw; rw = irw; br = ibr;
    build(imr, imw, irw);
    last_halt = 1'b0;
    for (int i = 0; i < tq.size(); i++) begin
      if (i > 0) @(negedge clock);
      check($sformatf("%s_cyc%0d", nm, i), {23'd0, obs_vec}, {23'd0, tq[i]});
      if (i == hcyc) begin
        halt_req = 1'b1;
        last_halt = 1'b1;
      end else begin
        halt_req = 1'b0;
      end
      if (i == tq.size() - 1 && release_at_retire) begin
        release dut_a.instr_count_r;
        release_at_retire = 1'b0;
      end
    end
    @(negedge clock);
    halt_req = 1'b0;
    exp_count = exp_count + 32'd1;
    check({nm, "_count"}, obs_count, exp_count);
    check({nm, "_next"}, {29'd0, obs_vec[8:6]}, last_halt ? 32'd6 : 32'd1);
    check({nm, "_halted"}, {31'd0, obs_halted}, {31'd0, last_halt});
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; halt_req = 1'b0;
    #1;
    check("rst_vec", {23'd0, obs_vec}, 32'd0);
    check("rst_count", obs_count, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    exp_count = 32'd0;
  endtask

  task automatic go();
    start = 1'b1; halt_req = 1'b0;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic random_run(input int n);
    logic [31:0] rv;
    int hc;
    for (int j = 0; j < n; j++) begin
      rv = $urandom;
      hc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      exec_instr(rv[0], rv[1], rv[2], rv[4:3], hc, "rnd");
      if (last_halt) go();
    end
  endtask

  initial begin
    #100000;
    $error("FAIL timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; cur_im = 1; cur_dm = 1;
    do_reset();
    check("idle_state", {29'd0, obs_vec[8:6]}, 32'd0);
    go();
    exec_instr(1'b0, 1'b0, 1'b1, 2'b00, -1, "alu");
    exec_instr(1'b1, 1'b0, 1'b1, 2'b00, -1, "load");
    exec_instr(1'b0, 1'b0, 1'b0, 2'b01, cur_im + 1, "br_halt");
    start = 1'b1; halt_req = 1'b1;
    @(negedge clock);
    check("halt_prio", {29'd0, obs_vec[8:6]}, 32'd6);
    check("halt_hold_cnt", obs_count, 32'd3);
    halt_req = 1'b0;
    @(negedge clock);
    start = 1'b0;
    check("resume", {29'd0, obs_vec[8:6]}, 32'd1);
    check("resume_halted", {31'd0, obs_halted}, 32'd0);
    exec_instr(1'b0, 1'b0, 1'b0, 2'b10, -1, "br");
    random_run(15);

    // Counter wrap from all-ones.
    do_reset();
    force dut_a.instr_count_r = 32'hFFFF_FFFF;
    exp_count = 32'hFFFF_FFFF;
    #1;
    check("wrap_pre", obs_count, 32'hFFFF_FFFF);
    release_at_retire = 1'b1;
    go();
    exec_instr(1'b0, 1'b0, 1'b1, 2'b00, -1, "wrap");

    sel = 1'b1; cur_im = 1; cur_dm = 3;
    do_reset();
    go();
    exec_instr(1'b0, 1'b1, 1'b0, 2'b00, -1, "store3");
    exec_instr(1'b1, 1'b0, 1'b1, 2'b00, -1, "load3");
    exec_instr(1'b1, 1'b1, 1'b1, 2'b00, -1, "rdwr3");
    exec_instr(1'b1, 1'b0, 1'b0, 2'b00, -1, "load_norw3");
    random_run(12);

    // Reset during the first MEM cycle of a store aborts without pc_en.
    do_reset();
    mr = 1'b0; mw = 1'b1; rw = 1'b0;
    go();
    repeat (4) @(negedge clock);
    check("pre_rst_mem", {23'd0, obs_vec}, {23'd0, pk(4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)});
    #2 reset = 1'b0;
    #1;
    check("mid_rst_vec", {23'd0, obs_vec}, 32'd0);
    check("mid_rst_halted", {31'd0, obs_halted}, 32'd0);
    check("mid_rst_count", obs_count, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_idle", {23'd0, obs_vec}, 32'd0);
    check("post_rst_count", obs_count, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
